// File: rtl/sprite_pkg.sv
// ---------------------------------------------------------------------------
// sprite_pkg
// Shared types and constants for the sprite renderer.
//   anim_state_t : animation sequencer states (IDLE / PLAY / HOLD)
//   rgb444_t     : packed 4-bit-per-channel pixel colour
//   PIPE_LATENCY : cycles from scan coordinate in to registered pixel out
//   paletteEntry : fixed 8-entry colour table used by sprite_palette
// ---------------------------------------------------------------------------
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2
    } anim_state_t;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb444_t;

    localparam int PIPE_LATENCY = 3;

    // Colour table shared by every sprite. Entry 0 is black because it is
    // normally the transparent index and should never reach the screen.
    function automatic rgb444_t paletteEntry(input logic [2:0] idx);
        rgb444_t c;
        case (idx)
            3'd0:    c = '{red: 4'h0, green: 4'h0, blue: 4'h0};
            3'd1:    c = '{red: 4'hF, green: 4'h0, blue: 4'h0};
            3'd2:    c = '{red: 4'h0, green: 4'hF, blue: 4'h0};
            3'd3:    c = '{red: 4'h0, green: 4'h0, blue: 4'hF};
            3'd4:    c = '{red: 4'hF, green: 4'hF, blue: 4'h0};
            3'd5:    c = '{red: 4'hF, green: 4'h8, blue: 4'h0};
            3'd6:    c = '{red: 4'h0, green: 4'hF, blue: 4'hF};
            default: c = '{red: 4'hF, green: 4'hF, blue: 4'hF};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sprite_palette.sv
// ---------------------------------------------------------------------------
// sprite_palette
// Combinational palette lookup: ROM palette index -> RGB444 colour.
// Only the low three index bits select a colour, so wider index widths
// repeat the 8-entry table.
// Ports:
//   i_idx  in  IDX_W  palette index read from the sprite ROM
//   o_rgb  out 12     colour for that index
// ---------------------------------------------------------------------------
module sprite_palette
    import sprite_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic [IDX_W-1:0] i_idx,
    output rgb444_t          o_rgb
);

    logic [IDX_W+2:0] w_idxExt;
    logic [2:0]       w_sel;
    logic             w_unused;

    // Zero-extend so the 3-bit table select is legal for any index width.
    assign w_idxExt = {3'b000, i_idx};
    assign w_sel    = w_idxExt[2:0];
    assign w_unused = ^w_idxExt[IDX_W+2:3];

    always_comb begin
        o_rgb = paletteEntry(w_sel);
    end

endmodule

// File: rtl/sprite_animator.sv
// ---------------------------------------------------------------------------
// sprite_animator
// Places one animated sprite at a programmable screen position. Each scan
// coordinate is hit-tested, turned into an address into an external
// synchronous sprite ROM, and the returned palette index is mapped to RGB444
// and registered. An IDLE/PLAY/HOLD sequencer steps through the animation
// frames on vertical-frame ticks, in loop or one-shot mode.
//
// Build option: define SPRITE_FLIP_EN to enable horizontal mirroring through
// the flip input. Without it the flip port is still present but ignored and
// no mirror logic is built.
//
// Ports:
//   vga_clk        in   pixel clock, all logic on posedge
//   reset          in   asynchronous, active-high
//   draw_x/draw_y  in   current scan coordinate
//   blank          in   1 = visible region
//   frame_tick     in   one pulse per video frame
//   pos_x/pos_y    in   sprite top-left corner
//   flip           in   horizontal mirror (SPRITE_FLIP_EN builds only)
//   anim_start     in   restart animation at frame 0
//   anim_loop      in   1 = loop, 0 = one-shot
//   rom_addr       out  registered address to the sprite ROM
//   rom_q          in   ROM data, one cycle after rom_addr
//   red/green/blue out  registered pixel colour
//   pixel_on       out  visible, inside the sprite and opaque
//   anim_busy      out  animation is playing
//   anim_done      out  one-cycle pulse when a one-shot run completes
// Pipeline: S1 address/hit/blank, S2 ROM read, S3 palette register; a pixel
// presented in cycle k appears on the colour outputs in cycle k+3.
// ---------------------------------------------------------------------------
module sprite_animator
    import sprite_pkg::*;
#(
    parameter  int SPR_W       = 64,
    parameter  int SPR_H       = 128,
    parameter  int FRAMES      = 4,
    parameter  int IDX_W       = 3,
    parameter  int FRAME_TICKS = 8,
    parameter  int TRANSP_IDX  = 0,
    parameter  int COORD_W     = 10,
    localparam int ADDR_W      = $clog2(FRAMES * SPR_W * SPR_H)
) (
    input  logic               vga_clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    input  logic               blank,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic               flip,
    input  logic               anim_start,
    input  logic               anim_loop,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [IDX_W-1:0]   rom_q,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               pixel_on,
    output logic               anim_busy,
    output logic               anim_done
);

    localparam int FRM_W  = (FRAMES > 1)      ? $clog2(FRAMES)      : 1;
    localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int COL_W  = (SPR_W > 1)       ? $clog2(SPR_W)       : 1;
    localparam int ROW_W  = (SPR_H > 1)       ? $clog2(SPR_H)       : 1;

    // Animation sequencer state
    anim_state_t       r_state;
    anim_state_t       w_nextState;
    logic [FRM_W-1:0]  r_frame;
    logic [FRM_W-1:0]  w_nextFrame;
    logic [TICK_W-1:0] r_tick;
    logic [TICK_W-1:0] w_nextTick;
    logic              r_done;
    logic              w_nextDone;

    // Address generation
    logic [COORD_W:0]  w_dx;
    logic [COORD_W:0]  w_dy;
    logic [COORD_W:0]  w_xEnd;
    logic [COORD_W:0]  w_yEnd;
    logic              w_hit;
    logic [COL_W-1:0]  w_col;
    logic [ADDR_W-1:0] w_addr;
    logic              w_unused;

    // Pipeline registers
    logic [ADDR_W-1:0] r_romAddr;
    logic              r_hit1;
    logic              r_blank1;
    logic              r_hit2;
    logic              r_blank2;
    rgb444_t           r_rgb;
    logic              r_pixelOn;
    rgb444_t           w_palRgb;
    logic              w_opaque;

    // -----------------------------------------------------------------------
    // Hit test and ROM address.
    // -----------------------------------------------------------------------

    // One extra bit on every coordinate so a sprite near the right/bottom
    // edge never wraps round to column/row zero.
    assign w_dx   = {1'b0, draw_x} - {1'b0, pos_x};
    assign w_dy   = {1'b0, draw_y} - {1'b0, pos_y};
    assign w_xEnd = {1'b0, pos_x} + (COORD_W+1)'(SPR_W);
    assign w_yEnd = {1'b0, pos_y} + (COORD_W+1)'(SPR_H);

    assign w_hit = ({1'b0, draw_x} >= {1'b0, pos_x}) && ({1'b0, draw_x} < w_xEnd) &&
                   ({1'b0, draw_y} >= {1'b0, pos_y}) && ({1'b0, draw_y} < w_yEnd);

`ifdef SPRITE_FLIP_EN
    assign w_col = flip ? (COL_W'(SPR_W - 1) - w_dx[COL_W-1:0]) : w_dx[COL_W-1:0];
`else
    assign w_col = w_dx[COL_W-1:0];
`endif

    // Only the in-sprite offset bits matter once the hit test has passed.
    assign w_unused = ^{flip, w_dx[COORD_W:COL_W], w_dy[COORD_W:ROW_W]};

    // Frames are stored back-to-back, each one a full row-major sprite image.
    assign w_addr = w_hit ? (ADDR_W'(r_frame) * ADDR_W'(SPR_W * SPR_H) +
                             ADDR_W'(w_dy[ROW_W-1:0]) * ADDR_W'(SPR_W) +
                             ADDR_W'(w_col))
                          : '0;

    // -----------------------------------------------------------------------
    // Animation sequencer: state register.
    // -----------------------------------------------------------------------
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_frame <= '0;
            r_tick  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_frame <= w_nextFrame;
            r_tick  <= w_nextTick;
            r_done  <= w_nextDone;
        end
    end

    // -----------------------------------------------------------------------
    // Animation sequencer: next state. A start request wins over a tick in
    // the same cycle; the loop mode is only consulted when the last frame
    // runs out.
    // -----------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        w_nextFrame = r_frame;
        w_nextTick  = r_tick;
        w_nextDone  = 1'b0;
        if (anim_start) begin
            w_nextState = PLAY;
            w_nextFrame = '0;
            w_nextTick  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_nextFrame = '0;
                    w_nextTick  = '0;
                end
                PLAY: begin
                    if (frame_tick) begin
                        if (r_tick == TICK_W'(FRAME_TICKS - 1)) begin
                            w_nextTick = '0;
                            if (r_frame == FRM_W'(FRAMES - 1)) begin
                                if (anim_loop) begin
                                    w_nextFrame = '0;
                                end else begin
                                    w_nextState = HOLD;
                                    w_nextDone  = 1'b1;
                                end
                            end else begin
                                w_nextFrame = r_frame + FRM_W'(1);
                            end
                        end else begin
                            w_nextTick = r_tick + TICK_W'(1);
                        end
                    end
                end
                HOLD: begin
                    w_nextFrame = r_frame;
                end
                default: begin
                    w_nextState = IDLE;
                    w_nextFrame = '0;
                    w_nextTick  = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Animation sequencer: outputs.
    // -----------------------------------------------------------------------
    always_comb begin
        anim_busy = (r_state == PLAY);
        anim_done = r_done;
    end

    // -----------------------------------------------------------------------
    // S1: register the ROM address together with the hit and blank flags of
    // the same pixel.
    // -----------------------------------------------------------------------
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_romAddr <= '0;
            r_hit1    <= 1'b0;
            r_blank1  <= 1'b0;
        end else begin
            r_romAddr <= w_addr;
            r_hit1    <= w_hit;
            r_blank1  <= blank;
        end
    end

    // -----------------------------------------------------------------------
    // S2: the external ROM is reading during this stage, so the flags are
    // delayed one more cycle to line up with rom_q.
    // -----------------------------------------------------------------------
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_hit2   <= 1'b0;
            r_blank2 <= 1'b0;
        end else begin
            r_hit2   <= r_hit1;
            r_blank2 <= r_blank1;
        end
    end

    sprite_palette #(
        .IDX_W (IDX_W)
    ) u_palette (
        .i_idx (rom_q),
        .o_rgb (w_palRgb)
    );

    assign w_opaque = r_hit2 && r_blank2 && (rom_q != IDX_W'(TRANSP_IDX));

    // -----------------------------------------------------------------------
    // S3: register the final colour; anything outside the sprite, in the
    // blanking interval or transparent is forced to black.
    // -----------------------------------------------------------------------
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_rgb     <= '0;
            r_pixelOn <= 1'b0;
        end else begin
            r_rgb     <= w_opaque ? w_palRgb : '0;
            r_pixelOn <= w_opaque;
        end
    end

    assign rom_addr = r_romAddr;
    assign red      = r_rgb.red;
    assign green    = r_rgb.green;
    assign blue     = r_rgb.blue;
    assign pixel_on = r_pixelOn;

endmodule

// File: tb/tb_sprite_animator.sv
// ---------------------------------------------------------------------------
// tb_sprite_animator
// Scoreboard bench for sprite_animator. A ROM model answers rom_addr one
// cycle later from a randomly filled array. The driver computes expected
// results from a tick-count animation model and pushes them into queues; a
// negedge monitor pops and compares whenever an expectation falls due.
// Honours SPRITE_FLIP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_sprite_animator;
    import sprite_pkg::*;

    localparam int SPR_W       = 64;
    localparam int SPR_H       = 128;
    localparam int FRAMES      = 4;
    localparam int IDX_W       = 3;
    localparam int FRAME_TICKS = 8;
    localparam int TRANSP_IDX  = 0;
    localparam int COORD_W     = 10;
    localparam int ROM_DEPTH   = FRAMES * SPR_W * SPR_H;
    localparam int ADDR_W      = $clog2(ROM_DEPTH);

`ifdef SPRITE_FLIP_EN
    localparam bit FLIP_ON = 1'b1;
`else
    localparam bit FLIP_ON = 1'b0;
`endif

    logic               vga_clk;
    logic               reset;
    logic [COORD_W-1:0] draw_x;
    logic [COORD_W-1:0] draw_y;
    logic               blank;
    logic               frame_tick;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic               flip;
    logic               anim_start;
    logic               anim_loop;
    logic [ADDR_W-1:0]  rom_addr;
    logic [IDX_W-1:0]   rom_q;
    logic [3:0]         red;
    logic [3:0]         green;
    logic [3:0]         blue;
    logic               pixel_on;
    logic               anim_busy;
    logic               anim_done;

    logic [IDX_W-1:0]   romMem [ROM_DEPTH];

    typedef struct {
        int due;
        int addr;
        bit busy;
        bit done;
    } s1Exp_t;

    typedef struct {
        int due;
        int rgb;
        bit on;
    } pixExp_t;

    s1Exp_t  s1Q[$];
    pixExp_t pixQ[$];

    int cycleCount = 0;
    int total      = 0;
    int bad        = 0;
    int doneSeen   = 0;

    // Animation model: total ticks since start decide the frame.
    bit mPlaying;
    bit mHolding;
    int mTicks;

    sprite_animator #(
        .SPR_W       (SPR_W),
        .SPR_H       (SPR_H),
        .FRAMES      (FRAMES),
        .IDX_W       (IDX_W),
        .FRAME_TICKS (FRAME_TICKS),
        .TRANSP_IDX  (TRANSP_IDX),
        .COORD_W     (COORD_W)
    ) dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .blank      (blank),
        .frame_tick (frame_tick),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .flip       (flip),
        .anim_start (anim_start),
        .anim_loop  (anim_loop),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .pixel_on   (pixel_on),
        .anim_busy  (anim_busy),
        .anim_done  (anim_done)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) cycleCount++;

    // Synchronous sprite ROM.
    always @(posedge vga_clk) rom_q <= romMem[rom_addr];

    always @(negedge vga_clk) if (anim_done === 1'b1) doneSeen++;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    function automatic int palRef(input int idx);
        case (idx % 8)
            0:       return 'h000;
            1:       return 'hF00;
            2:       return 'h0F0;
            3:       return 'h00F;
            4:       return 'hFF0;
            5:       return 'hF80;
            6:       return 'h0FF;
            default: return 'hFFF;
        endcase
    endfunction

    function automatic bit isHit(input int x, input int y, input int px, input int py);
        return (x >= px) && (x < px + SPR_W) && (y >= py) && (y < py + SPR_H);
    endfunction

    function automatic int expAddr(input int x, input int y, input int px, input int py,
                                   input bit fl, input int frm);
        int col;
        if (!isHit(x, y, px, py)) return 0;
        col = x - px;
        if (fl && FLIP_ON) col = SPR_W - 1 - col;
        return frm * SPR_W * SPR_H + (y - py) * SPR_W + col;
    endfunction

    function automatic int modelFrame();
        if (mHolding) return FRAMES - 1;
        if (mPlaying) return mTicks / FRAME_TICKS;
        return 0;
    endfunction

    // Drive one cycle of inputs and queue what must come out of it.
    task automatic applyStimulus(input int x, input int y, input int px, input int py,
                                 input bit bl, input bit ft, input bit st,
                                 input bit lp, input bit fl);
        int      addr;
        int      idx;
        s1Exp_t  e1;
        pixExp_t e3;
        @(posedge vga_clk);
        #1;
        draw_x     = COORD_W'(x);
        draw_y     = COORD_W'(y);
        pos_x      = COORD_W'(px);
        pos_y      = COORD_W'(py);
        blank      = bl;
        frame_tick = ft;
        anim_start = st;
        anim_loop  = lp;
        flip       = fl;
        addr   = expAddr(x, y, px, py, fl, modelFrame());
        idx    = int'(romMem[addr]);
        e3.due = cycleCount + PIPE_LATENCY;
        e3.on  = bl && isHit(x, y, px, py) && (idx != TRANSP_IDX);
        e3.rgb = e3.on ? palRef(idx) : 0;
        e1.done = 1'b0;
        if (st) begin
            mPlaying = 1'b1;
            mHolding = 1'b0;
            mTicks   = 0;
        end else if (ft && mPlaying) begin
            mTicks++;
            if (mTicks == FRAMES * FRAME_TICKS) begin
                if (lp) begin
                    mTicks = 0;
                end else begin
                    mPlaying = 1'b0;
                    mHolding = 1'b1;
                    e1.done  = 1'b1;
                end
            end
        end
        e1.due  = cycleCount + 1;
        e1.addr = addr;
        e1.busy = mPlaying;
        s1Q.push_back(e1);
        pixQ.push_back(e3);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rom_addr"}, int'(rom_addr), 0);
        checkOutput({tag, "_rgb"}, int'({red, green, blue}), 0);
        checkOutput({tag, "_pixel_on"}, int'(pixel_on), 0);
        checkOutput({tag, "_anim_busy"}, int'(anim_busy), 0);
        checkOutput({tag, "_anim_done"}, int'(anim_done), 0);
    endtask

    task automatic doMidReset();
        @(posedge vga_clk);
        #1;
        reset      = 1'b1;
        frame_tick = 1'b0;
        anim_start = 1'b0;
        s1Q.delete();
        pixQ.delete();
        mPlaying = 1'b0;
        mHolding = 1'b0;
        mTicks   = 0;
        #1;
        checkResetOutputs("midreset");
        repeat (2) @(posedge vga_clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compare whatever expectation is due this cycle.
    always @(negedge vga_clk) begin
        if (s1Q.size() > 0 && s1Q[0].due <= cycleCount) begin
            s1Exp_t e;
            e = s1Q.pop_front();
            checkOutput("rom_addr", int'(rom_addr), e.addr);
            checkOutput("anim_busy", int'(anim_busy), int'(e.busy));
            checkOutput("anim_done", int'(anim_done), int'(e.done));
        end
        if (pixQ.size() > 0 && pixQ[0].due <= cycleCount) begin
            pixExp_t p;
            p = pixQ.pop_front();
            checkOutput("rgb", int'({red, green, blue}), p.rgb);
            checkOutput("pixel_on", int'(pixel_on), int'(p.on));
        end
    end

    initial begin
        int px;
        int py;
        int x;
        int y;
        int doneBase;
        bit loopMode;
        reset      = 1'b1;
        draw_x     = '0;
        draw_y     = '0;
        blank      = 1'b0;
        frame_tick = 1'b0;
        pos_x      = '0;
        pos_y      = '0;
        flip       = 1'b0;
        anim_start = 1'b0;
        anim_loop  = 1'b0;
        mPlaying   = 1'b0;
        mHolding   = 1'b0;
        mTicks     = 0;
        for (int i = 0; i < ROM_DEPTH; i++) romMem[i] = IDX_W'($urandom_range(0, 7));
        romMem[0]     = 3'd5;
        romMem[63]    = 3'd5;
        romMem[8191]  = 3'd0;
        romMem[24576] = 3'd3;

        #12;
        checkResetOutputs("reset");
        @(posedge vga_clk);
        #1;
        reset = 1'b0;

        // Corners and edges, frame 0, idle sequencer.
        applyStimulus(100, 50, 100, 50, 1, 0, 0, 0, 0);
        applyStimulus(163, 177, 100, 50, 1, 0, 0, 0, 0);
        applyStimulus(164, 50, 100, 50, 1, 0, 0, 0, 0);
        applyStimulus(99, 50, 100, 50, 1, 0, 0, 0, 0);
        applyStimulus(100, 49, 100, 50, 1, 0, 0, 0, 0);
        applyStimulus(163, 178, 100, 50, 1, 0, 0, 0, 0);
        applyStimulus(100, 50, 100, 50, 0, 0, 0, 0, 0);
        applyStimulus(100, 50, 100, 50, 1, 0, 0, 0, 1);
        applyStimulus(1023, 1023, 1000, 1000, 1, 0, 0, 0, 0);
        applyStimulus(5, 5, 1000, 1000, 1, 0, 0, 0, 0);

        // One-shot run.
        doneBase = doneSeen;
        applyStimulus(100, 50, 100, 50, 1, 0, 1, 0, 0);
        for (int i = 0; i < FRAMES * FRAME_TICKS; i++) begin
            applyStimulus(100, 50, 100, 50, 1, 1, 0, 0, 0);
            repeat ($urandom_range(0, 2)) applyStimulus(100, 50, 100, 50, 1, 0, 0, 0, 0);
        end
        repeat (4) applyStimulus(100, 50, 100, 50, 1, 0, 0, 0, 0);
        checkOutput("oneshot_done_count", doneSeen - doneBase, 1);

        // Looping run, then a start coincident with a tick.
        doneBase = doneSeen;
        applyStimulus(100, 50, 100, 50, 1, 0, 1, 1, 0);
        for (int i = 0; i < FRAMES * FRAME_TICKS; i++) begin
            applyStimulus(100, 50, 100, 50, 1, 1, 0, 1, 0);
        end
        repeat (3) applyStimulus(100, 50, 100, 50, 1, 0, 0, 1, 0);
        checkOutput("loop_done_count", doneSeen - doneBase, 0);
        for (int i = 0; i < 12; i++) applyStimulus(100, 50, 100, 50, 1, 1, 0, 1, 0);
        applyStimulus(100, 50, 100, 50, 1, 1, 1, 1, 0);
        for (int i = 0; i < FRAME_TICKS; i++) applyStimulus(100, 50, 100, 50, 1, 1, 0, 1, 0);
        repeat (2) applyStimulus(100, 50, 100, 50, 1, 0, 0, 1, 0);

        // Reset while playing frame 2.
        applyStimulus(100, 50, 100, 50, 1, 0, 1, 0, 0);
        for (int i = 0; i < 2 * FRAME_TICKS; i++) applyStimulus(100, 50, 100, 50, 1, 1, 0, 0, 0);
        repeat (4) applyStimulus(100, 50, 100, 50, 1, 0, 0, 0, 0);
        doMidReset();
        repeat (4) applyStimulus(100, 50, 100, 50, 1, 0, 0, 0, 0);

        // Randomised traffic.
        px = 100;
        py = 50;
        loopMode = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (n % 100 == 50) begin
                px = int'($urandom_range(0, 1023));
                py = int'($urandom_range(0, 1023));
            end
            x = px + int'($urandom_range(0, SPR_W + 40)) - 20;
            y = py + int'($urandom_range(0, SPR_H + 40)) - 20;
            if (x < 0) x = 0;
            if (x > 1023) x = 1023;
            if (y < 0) y = 0;
            if (y > 1023) y = 1023;
            applyStimulus(x, y, px, py, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                          (n == 0) || ($urandom_range(0, 60) == 0), loopMode,
                          $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 40) == 0) loopMode = ~loopMode;
        end

        repeat (PIPE_LATENCY + 1) @(posedge vga_clk);
        #1;
        checkOutput("drain_s1", s1Q.size(), 0);
        checkOutput("drain_pix", pixQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_animator.md
# sprite_animator

Parametrised multi-frame sprite renderer for the VGA pipeline. Places one animated sprite at a programmable screen position. For each scan coordinate it generates the sprite ROM address, reads a palette index from an external synchronous ROM, maps the index to RGB444 and registers the pixel. It also steps through animation frames on vertical-frame ticks, with loop or one-shot mode and optional horizontal mirroring, and exposes per-pixel opacity for compositing.

## Interface
- SPR_W, 64, sprite width in pixels
- SPR_H, 128, sprite height in pixels
- FRAMES, 4, animation frames stored back-to-back in ROM
- IDX_W, 3, palette index width
- FRAME_TICKS, 8, frame_tick pulses per animation frame (≥1)
- TRANSP_IDX, 0, palette index treated as transparent
- COORD_W, 10, screen coordinate width
- ADDR_W, $clog2(FRAMES*SPR_W*SPR_H), ROM address width (derived)

Ports:
- vga_clk  in  1  pixel clock; all logic on posedge
- reset  in  1  asynchronous, active-high
- draw_x, draw_y  in  COORD_W  current scan coordinate
- blank  in  1  display enable; 1 = visible region
- frame_tick  in  1  one-cycle pulse once per video frame (vsync)
- pos_x, pos_y  in  COORD_W  sprite top-left corner
- flip  in  1  horizontal mirror
- anim_start  in  1  pulse: restart animation at frame 0
- anim_loop  in  1  1 = loop, 0 = one-shot
- rom_addr  out  ADDR_W  registered address to external ROM
- rom_q  in  IDX_W  ROM data, valid one cycle after rom_addr
- red, green, blue  out  4 each  registered pixel colour
- pixel_on  out  1  pixel is visible, in-sprite and opaque
- anim_busy  out  1  state == PLAY
- anim_done  out  1  one-cycle pulse at one-shot completion

## Operation
- Hit test uses COORD_W+1-bit arithmetic, so there is no wrap: hit = draw_x∈[pos_x, pos_x+SPR_W) and draw_y∈[pos_y, pos_y+SPR_H).
- Column: col = draw_x−pos_x, or SPR_W−1−col when flip is set. Row: row = draw_y−pos_y.
- rom_addr = frame·SPR_W·SPR_H + row·SPR_W + col. When there is no hit, rom_addr = 0.
- Output:
  - blank & hit & rom_q≠TRANSP_IDX gives the palette colour with pixel_on=1.
  - Any other case gives RGB 0 with pixel_on=0.
- Animation FSM (states IDLE, PLAY, HOLD):
  - IDLE: frame=0. anim_start → PLAY with frame=0 and tick=0.
  - PLAY: on each frame_tick, tick increments. When tick==FRAME_TICKS−1, tick resets to 0 and frame advances.
  - Wrap from the last frame: with anim_loop=1, frame→0 and the FSM stays in PLAY. With anim_loop=0, frame stays at FRAMES−1, the FSM enters HOLD and anim_done pulses.
  - HOLD: last frame is displayed. anim_start → PLAY.
- anim_start takes priority over a simultaneous frame_tick. Asserting anim_start during PLAY restarts from frame 0.
- anim_loop is sampled at the wrap point only.
- frame changes only on frame_tick or anim_start edges.

## Timing
- Three-stage pipeline; inputs at cycle k appear on red/green/blue/pixel_on at cycle k+3.
  - S1 registers rom_addr, hit and blank.
  - S2 is the ROM read; hit and blank are delayed alongside it.
  - S3 registers the palette output.
- hit, blank and the transparency decision travel with the data. There are no bubbles and no stalls.
- Reset state: every output is 0, the FSM is in IDLE, frame=0, tick=0, and all pipeline valid/hit flags are cleared.
- Reset in mid-animation returns to IDLE immediately. Outputs are 0 until three cycles after reset deasserts.
- anim_done is high for exactly one cycle, in the cycle after the wrapping frame_tick.

## Configuration
- SPRITE_FLIP_EN defined: the flip input mirrors columns as described above.
- SPRITE_FLIP_EN undefined: the flip port stays present but is ignored, col = draw_x−pos_x, and no mirror logic is synthesised.

## Structure
- Package sprite_pkg holds:
  - typedef anim_state_t {IDLE, PLAY, HOLD}
  - typedef rgb444_t struct
  - localparam PIPE_LATENCY = 3
- Sub-module sprite_palette: combinational IDX_W index → rgb444_t lookup, instantiated once after S2.

## Test plan
Defaults throughout, with pos=(100,50).
- Corners, frame 0, flip=0:
  - draw=(100,50) → rom_addr 0.
  - draw=(163,177) → rom_addr 8191.
  - draw=(164,50) → pixel_on=0 three cycles later.
- Flip (macro defined): draw=(100,50) with flip=1 → rom_addr 63. Macro undefined → rom_addr 0.
- Transparency:
  - rom_q=0 at a hit → pixel_on=0 and RGB 0.
  - rom_q=5 with blank=1 → palette[5] and pixel_on=1 at k+3.
  - Same with blank=0 → 0.
- One-shot: anim_start, then 32 frame_ticks → frame steps 0→3 every 8 ticks, anim_done pulses once, state HOLD, rom_addr base 24576.
- Loop and priority:
  - anim_loop=1, 32 ticks → frame back to 0 with no anim_done.
  - anim_start coincident with frame_tick → frame=0 and tick=0.
- Reset mid-PLAY at frame 2 → immediate IDLE and outputs 0. After release, frame 0 base addr is 0.
